uart_rx_engine: RTL and testbench

UART receive engine. It is the counterpart of the transmit engine and shares the same 19-bit baud count and the same EIGHT/PEN/OHEL frame controls. It deserializes the RX line into a byte and raises RXRDY. The TramelBlaze interrupt path (ped/SR_FF) picks up RXRDY, and the firmware reads the data and status words through the port decoder, which issues a single-cycle read0 strobe.

---
 rtl/uart_rx_engine.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
// UART receive engine: deserializes RX into a byte, raises RXRDY and error flags.
// Latency: RXRDY rises SYNC_STAGES + 2 + baud/2 + N*baud clocks after the start edge (N = 8..10).
// Backpressure: none on the line; a byte not taken by read0 before the next one sets OVF.
//
// Ports:
//   clk, resetNew       : system clock, asynchronous active-high reset
//   RX                  : serial line (idles high), synchronized internally
//   baud                : clocks per bit time (4 and up)
//   EIGHT, PEN, OHEL    : 8/7 data bits, parity enable, parity sense (1 = odd)
//   read0               : one-cycle strobe, firmware consumed data/status
//   rx_data             : received byte (bit 7 = 0 in 7-bit mode)
//   RXRDY, PERR, FERR   : byte ready, parity error, framing error
//   OVF, BRK            : overrun, break detected
// Optional feature macro: RX_BREAK_DETECT_EN (break detection + BREAK wait state).
// Without it BRK is tied low and a held-low line reads as 0x00 frames with FERR.

module uart_rx_engine #(
  parameter int SYNC_STAGES = 2,
  parameter int BAUD_W      = 19
) (
  input  logic              clk,
  input  logic              resetNew,
  input  logic              RX,
  input  logic [BAUD_W-1:0] baud,
  input  logic              EIGHT,
  input  logic              PEN,
  input  logic              OHEL,
  input  logic              read0,
  output logic [7:0]        rx_data,
  output logic              RXRDY,
  output logic              PERR,
  output logic              FERR,
  output logic              OVF,
  output logic              BRK
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef RX_BREAK_DETECT_EN
  localparam logic [2:0] S_BREAK  = 3'd5;
`endif

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs;

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] timer_q, timer_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              eight_q, eight_d;
  logic              pen_q, pen_d;
  logic              ohel_q, ohel_d;
  logic              perr_calc_q, perr_calc_d;
  logic              ferr_calc_q, ferr_calc_d;
  logic              done_q, done_d;

  logic [7:0]        rx_data_q, rx_data_d;
  logic              rxrdy_q, rxrdy_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovf_q, ovf_d;

`ifdef RX_BREAK_DETECT_EN
  logic              zero_q, zero_d;       // every sample so far in this frame was 0
  logic              brk_calc_q, brk_calc_d;
  logic              brk_q, brk_d;
`endif

  logic              tick;
  logic [BAUD_W-1:0] half_load;
  logic [BAUD_W-1:0] full_load;
  logic              data_last;
  logic [7:0]        byte_asm;

  assign rxs = sync_q[SYNC_STAGES-1];

  // The timer expires one clock after reaching 0, so loads are one less than
  // the wanted interval: half a bit to reach mid-start, then a full bit.
  assign tick      = (timer_q == '0);
  assign half_load = (baud >> 1) - BAUD_W'(1);
  assign full_load = baud - BAUD_W'(1);
  assign data_last = (bit_cnt_q == (eight_q ? 4'd7 : 4'd6));

  // Bits enter at the MSB; in 7-bit mode the byte sits one position high.
  assign byte_asm  = eight_q ? shift_q : {1'b0, shift_q[7:1]};

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], RX};
    state_d     = state_q;
    timer_d     = tick ? timer_q : timer_q - BAUD_W'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    eight_d     = eight_q;
    pen_d       = pen_q;
    ohel_d      = ohel_q;
    perr_calc_d = perr_calc_q;
    ferr_calc_d = ferr_calc_q;
    done_d      = 1'b0;
`ifdef RX_BREAK_DETECT_EN
    zero_d      = zero_q;
    brk_calc_d  = brk_calc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          timer_d = half_load;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (rxs) begin
            state_d = S_IDLE;           // glitch, not a start bit
          end else begin
            timer_d   = full_load;
            bit_cnt_d = 4'd0;
            shift_d   = 8'h00;
            eight_d   = EIGHT;
            pen_d     = PEN;
            ohel_d    = OHEL;
`ifdef RX_BREAK_DETECT_EN
            zero_d    = 1'b1;
`endif
            state_d   = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d   = {rxs, shift_q[7:1]};
          timer_d   = full_load;
          bit_cnt_d = bit_cnt_q + 4'd1;
`ifdef RX_BREAK_DETECT_EN
          if (rxs) zero_d = 1'b0;
`endif
          if (data_last) state_d = pen_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (tick) begin
          perr_calc_d = (^byte_asm) ^ rxs ^ ohel_q;
          timer_d     = full_load;
          bit_cnt_d   = bit_cnt_q + 4'd1;
`ifdef RX_BREAK_DETECT_EN
          if (rxs) zero_d = 1'b0;
`endif
          state_d     = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          ferr_calc_d = ~rxs;
          bit_cnt_d   = bit_cnt_q + 4'd1;
          done_d      = 1'b1;
`ifdef RX_BREAK_DETECT_EN
          brk_calc_d  = zero_q & ~rxs;
          // Park until the line recovers so a long break yields one frame.
          state_d     = (zero_q & ~rxs) ? S_BREAK : S_IDLE;
`else
          state_d     = S_IDLE;
`endif
        end
      end
`ifdef RX_BREAK_DETECT_EN
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Status/data registers: completion has priority over the read strobe.
  always_comb begin
    rx_data_d = rx_data_q;
    rxrdy_d   = rxrdy_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovf_d     = ovf_q;
`ifdef RX_BREAK_DETECT_EN
    brk_d     = brk_q;
`endif
    if (done_q) begin
      rx_data_d = byte_asm;
      perr_d    = perr_calc_q & pen_q;
      ferr_d    = ferr_calc_q;
      rxrdy_d   = 1'b1;
      ovf_d     = ovf_q | (rxrdy_q & ~read0);
`ifdef RX_BREAK_DETECT_EN
      brk_d     = brk_calc_q;
`endif
    end else if (read0 && rxrdy_q) begin
      rxrdy_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovf_d   = 1'b0;
`ifdef RX_BREAK_DETECT_EN
      brk_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge resetNew) begin
    if (resetNew) begin
      sync_q      <= '1;                // line idles high; no false start out of reset
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      eight_q     <= 1'b0;
      pen_q       <= 1'b0;
      ohel_q      <= 1'b0;
      perr_calc_q <= 1'b0;
      ferr_calc_q <= 1'b0;
      done_q      <= 1'b0;
      rx_data_q   <= 8'h00;
      rxrdy_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
      zero_q      <= 1'b0;
      brk_calc_q  <= 1'b0;
      brk_q       <= 1'b0;
`endif
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      eight_q     <= eight_d;
      pen_q       <= pen_d;
      ohel_q      <= ohel_d;
      perr_calc_q <= perr_calc_d;
      ferr_calc_q <= ferr_calc_d;
      done_q      <= done_d;
      rx_data_q   <= rx_data_d;
      rxrdy_q     <= rxrdy_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovf_q       <= ovf_d;
`ifdef RX_BREAK_DETECT_EN
      zero_q      <= zero_d;
      brk_calc_q  <= brk_calc_d;
      brk_q       <= brk_d;
`endif
    end
  end

  assign rx_data = rx_data_q;
  assign RXRDY   = rxrdy_q;
  assign PERR    = perr_q;
  assign FERR    = ferr_q;
  assign OVF     = ovf_q;
`ifdef RX_BREAK_DETECT_EN
  assign BRK     = brk_q;
`else
  assign BRK     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: a frame table plus hand-written corner sequences.
// Frames are driven at baud = 16; outputs sampled 1 ns after the rising edge.
// Optional break behaviour is checked in whichever form the macro selects.

module tb_uart_rx_engine;

  localparam int SYNC = 2;
  localparam int BW   = 19;
  localparam int BAUD = 16;

  logic          clk = 1'b0;
  logic          resetNew = 1'b0;
  logic          RX = 1'b1;
  logic [BW-1:0] baud = BW'(BAUD);
  logic          EIGHT = 1'b1;
  logic          PEN = 1'b0;
  logic          OHEL = 1'b0;
  logic          read0 = 1'b0;
  logic [7:0]    rx_data;
  logic          RXRDY, PERR, FERR, OVF, BRK;

  int total = 0;
  int bad   = 0;

  uart_rx_engine #(.SYNC_STAGES(SYNC), .BAUD_W(BW)) dut (
    .clk(clk), .resetNew(resetNew), .RX(RX), .baud(baud),
    .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL), .read0(read0),
    .rx_data(rx_data), .RXRDY(RXRDY), .PERR(PERR), .FERR(FERR),
    .OVF(OVF), .BRK(BRK)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    logic       eight, pen, ohel, par, stop;
    logic [7:0] exp_dat;
    logic       exp_perr, exp_ferr;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] d, input logic e, input logic p,
                              input logic o, input logic pb, input logic sb,
                              input logic [7:0] xd, input logic xp, input logic xf);
    vec_t v;
    v.dat = d; v.eight = e; v.pen = p; v.ohel = o; v.par = pb; v.stop = sb;
    v.exp_dat = xd; v.exp_perr = xp; v.exp_ferr = xf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    RX = b;
    repeat (BAUD) @(posedge clk);
    #1;
  endtask

  // Start, data LSB first, optional parity, stop, then two idle bit times.
  task automatic send_frame(input logic [7:0] d, input logic e, input logic p,
                            input logic pb, input logic sb);
    int nb = e ? 8 : 7;
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (p) drive_bit(pb);
    drive_bit(sb);
    RX = 1'b1;
    repeat (2 * BAUD) @(posedge clk);
    #1;
  endtask

  task automatic pulse_read();
    read0 = 1'b1;
    @(posedge clk);
    #1;
    read0 = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rdy"},  RXRDY,   0);
    chk({nm, "_data"}, rx_data, 0);
    chk({nm, "_perr"}, PERR,    0);
    chk({nm, "_ferr"}, FERR,    0);
    chk({nm, "_ovf"},  OVF,     0);
    chk({nm, "_brk"},  BRK,     0);
  endtask

  vec_t vecs [0:8];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n_bits;
    int exp_lat;

    // 0x41 in 7 bits has two ones; 0x80 one; 0x7F seven; 0xC3 sent as 7 bits is 0x43.
    vecs[0] = mk(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    vecs[1] = mk(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
    vecs[2] = mk(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0);
    vecs[3] = mk(8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0);
    vecs[4] = mk(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1);
    vecs[5] = mk(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    vecs[6] = mk(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h43, 1'b0, 1'b0);
    vecs[7] = mk(8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
    vecs[8] = mk(8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0);

    // Reset
    #1 resetNew = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    resetNew = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Frame table: data, flags and completion latency, then read0 clears.
    for (int k = 0; k < 9; k++) begin
      EIGHT = vecs[k].eight;
      PEN   = vecs[k].pen;
      OHEL  = vecs[k].ohel;
      lat   = 0;
      fork
        send_frame(vecs[k].dat, vecs[k].eight, vecs[k].pen, vecs[k].par, vecs[k].stop);
        begin
          while (!RXRDY && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
          end
        end
      join
      n_bits  = 7 + int'(vecs[k].eight) + int'(vecs[k].pen) + 1;
      exp_lat = SYNC + 2 + BAUD / 2 + n_bits * BAUD;
      chk($sformatf("v%0d_lat(%0d)", k, lat), (lat >= exp_lat - 2) && (lat <= exp_lat + 2), 1);
      chk($sformatf("v%0d_rdy", k),  RXRDY,   1);
      chk($sformatf("v%0d_data", k), rx_data, vecs[k].exp_dat);
      chk($sformatf("v%0d_perr", k), PERR,    vecs[k].exp_perr);
      chk($sformatf("v%0d_ferr", k), FERR,    vecs[k].exp_ferr);
      chk($sformatf("v%0d_ovf", k),  OVF,     0);
      pulse_read();
      chk($sformatf("v%0d_rd_rdy", k),  RXRDY,   0);
      chk($sformatf("v%0d_rd_perr", k), PERR,    0);
      chk($sformatf("v%0d_rd_ferr", k), FERR,    0);
      chk($sformatf("v%0d_rd_hold", k), rx_data, vecs[k].exp_dat);
    end

    // Overrun: second byte lands while the first is unread.
    EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("ovf_data", rx_data, 8'h22);
    chk("ovf_set",  OVF,     1);
    chk("ovf_rdy",  RXRDY,   1);
    pulse_read();
    chk("ovf_clr",     OVF,   0);
    chk("ovf_rd_rdy",  RXRDY, 0);
    pulse_read();
    chk("idle_read_hold", rx_data, 8'h22);

    // read0 on the same edge as completion: completion wins, no overrun.
    // Completion edge is SYNC + 1 + BAUD/2 + 9*BAUD edges after the start bit.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    fork
      send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
      begin
        repeat (SYNC + 1 + BAUD / 2 + 9 * BAUD) @(posedge clk);
        #1 read0 = 1'b1;
        @(posedge clk);
        #1 read0 = 1'b0;
      end
    join
    chk("coinc_rdy",  RXRDY,   1);
    chk("coinc_ovf",  OVF,     0);
    chk("coinc_data", rx_data, 8'h22);
    pulse_read();

    // Short low glitch is rejected at the mid-start check.
    RX = 1'b0;
    repeat (4) @(posedge clk);
    #1 RX = 1'b1;
    repeat (3 * BAUD) @(posedge clk);
    #1;
    chk("glitch_rdy", RXRDY, 0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("post_glitch_data", rx_data, 8'h81);
    chk("post_glitch_rdy",  RXRDY,   1);

    // Asynchronous reset in the middle of a 0xFF frame.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    resetNew = 1'b1;
    #2;
    chk("async_rst_rdy",  RXRDY,   0);
    chk("async_rst_data", rx_data, 0);
    RX = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetNew = 1'b0;
    chk_all_zero("midrst");
    repeat (2 * BAUD) @(posedge clk);
    #1;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("post_rst_data", rx_data, 8'h3C);
    chk("post_rst_rdy",  RXRDY,   1);
    chk("post_rst_ferr", FERR,    0);
    pulse_read();

    // Line held low for 30 bit times.
    RX = 1'b0;
    repeat (30 * BAUD) @(posedge clk);
    #1;
    chk("brk_data", rx_data, 8'h00);
    chk("brk_ferr", FERR,    1);
    chk("brk_rdy",  RXRDY,   1);
`ifdef RX_BREAK_DETECT_EN
    chk("brk_flag", BRK, 1);
    chk("brk_ovf",  OVF, 0);
`else
    chk("brk_flag", BRK, 0);
    chk("brk_ovf",  OVF, 1);
`endif
    RX = 1'b1;
    repeat (12 * BAUD) @(posedge clk);
    #1;
`ifdef RX_BREAK_DETECT_EN
    chk("brk_single", OVF, 0);
`endif
    pulse_read();
    chk("brk_rd_rdy", RXRDY, 0);
    chk("brk_rd_brk", BRK,   0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("post_brk_data", rx_data, 8'h5A);
    chk("post_brk_ferr", FERR,    0);
    chk("post_brk_brk",  BRK,     0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
